// File: rtl/gpio_board_pkg.sv
// Shared constants and helpers for the GPIO board blocks (switch reader, LED/display side).
package gpio_board_pkg;

    localparam int GPIO_WIDTH        = 32;
    localparam int GPIO_FRAME_CYCLES = 131072;
    localparam int GPIO_IDX_W        = 5;
    localparam int GPIO_DB_CNT_W     = 4;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [GPIO_IDX_W-1:0] lowest_set(input logic [GPIO_WIDTH-1:0] v);
        lowest_set = '0;
        for (int i = GPIO_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = GPIO_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One switch debouncer: counts consecutive differing ticks and flips the stable level
// after DEBOUNCE_N of them, emitting a one-cycle change pulse on the flipping tick.
module gpio_debounce_bit
    import gpio_board_pkg::*;
#(
    parameter int DEBOUNCE_N = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic prime_i,
    input  logic tick_i,
    input  logic raw_i,
    output logic stable_o,
    output logic change_o
);

    localparam logic [GPIO_DB_CNT_W-1:0] LAST = GPIO_DB_CNT_W'(DEBOUNCE_N);

    logic [GPIO_DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                     stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        change_o = 1'b0;
        if (prime_i) begin
            stable_d = raw_i;
            cnt_d    = '0;
        end else if (tick_i) begin
            if (raw_i == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q + 1'b1 == LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
                change_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/gpio_switch_reader.sv
// Debounces the 32 DIP switches once per scan frame and serializes changes as events.
// Optional GPIO_SW_SYNC_EN inserts a 2-flop synchronizer ahead of tick sampling.
module gpio_switch_reader
    import gpio_board_pkg::*;
#(
    parameter int TICK_DIV   = GPIO_FRAME_CYCLES,
    parameter int DEBOUNCE_N = 3
) (
    input  logic                  clock_50,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] DIP_SW,
    output logic [GPIO_WIDTH-1:0] sw_stable,
    output logic                  sw_primed,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [GPIO_IDX_W-1:0] event_index,
    output logic                  event_level
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TCW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                  tick, prime, tick_en;
    logic                  primed_q, primed_d;
    logic [GPIO_WIDTH-1:0] sw_sample;
    logic [GPIO_WIDTH-1:0] stable_vec, change_vec;
    logic [GPIO_WIDTH-1:0] pending_q, pending_d, clear_mask;
    logic                  valid_q, valid_d;
    logic [GPIO_IDX_W-1:0] idx_q, idx_d, load_idx;
    logic                  level_q, level_d;
    logic                  slot_free, load;

`ifdef GPIO_SW_SYNC_EN
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= DIP_SW;
            sync2_q <= sync1_q;
        end
    end
    assign sw_sample = sync2_q;
`else
    assign sw_sample = DIP_SW;
`endif

    assign tick       = (tick_cnt_q == TCW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign prime      = tick && !primed_q;
    assign tick_en    = tick && primed_q;
    assign primed_d   = primed_q | tick;

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_bit
        gpio_debounce_bit #(.DEBOUNCE_N(DEBOUNCE_N)) u_db (
            .clk_i    (clock_50),
            .rst_i    (reset),
            .prime_i  (prime),
            .tick_i   (tick_en),
            .raw_i    (sw_sample[g]),
            .stable_o (stable_vec[g]),
            .change_o (change_vec[g])
        );
    end

    // Event handshake: an event transfers on a cycle with event_valid && event_ready;
    // while event_valid is high and event_ready low, index and level hold unchanged.
    // A pending bit set by this cycle's tick survives a same-cycle load of that bit.
    always_comb begin
        slot_free  = !valid_q || event_ready;
        load       = slot_free && (pending_q != '0);
        load_idx   = lowest_set(pending_q);
        clear_mask = load ? (GPIO_WIDTH'(1) << load_idx) : '0;
        pending_d  = (pending_q & ~clear_mask) | change_vec;
        valid_d    = slot_free ? load : valid_q;
        idx_d      = load ? load_idx : idx_q;
        level_d    = load ? stable_vec[load_idx] : level_q;
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            primed_q   <= 1'b0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            level_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            primed_q   <= primed_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
        end
    end

    assign sw_stable   = stable_vec;
    assign sw_primed   = primed_q;
    assign event_valid = valid_q;
    assign event_index = idx_q;
    assign event_level = level_q;

endmodule

// File: tb/tb_gpio_switch_reader.sv
// Directed bench for gpio_switch_reader with a tick-level behavioural model and an event queue.
module tb_gpio_switch_reader;

    localparam int TICK_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dip = 32'h0000_00F0;
    logic        ready = 1'b1;
    logic [31:0] sw_stable;
    logic        sw_primed;
    logic        event_valid;
    logic [4:0]  event_index;
    logic        event_level;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] exp_q[$];

    // behavioural model state
    int          m_n;
    bit          m_primed;
    logic [31:0] m_stable;
    logic [31:0] m_pend;
    bit          m_valid;
    logic [4:0]  m_idx;
    logic        m_level;
    int          m_run[32];

    gpio_switch_reader #(.TICK_DIV(TICK_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
        .clock_50    (clk),
        .reset       (rst),
        .DIP_SW      (dip),
        .sw_stable   (sw_stable),
        .sw_primed   (sw_primed),
        .event_valid (event_valid),
        .event_ready (ready),
        .event_index (event_index),
        .event_level (event_level)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_primed = 0; m_stable = '0; m_pend = '0;
        m_valid = 0; m_idx = '0; m_level = 1'b0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
    endtask

    // One clock of the model: drain slot from pre-edge state, then apply this edge's tick.
    task automatic model_step();
        bit tick;
        m_n++;
        tick = (m_n % TICK_DIV) == 0;
        if (!m_valid || ready) begin
            m_valid = 0;
            for (int j = 0; j < 32; j++) begin
                if (m_pend[j]) begin
                    m_valid   = 1;
                    m_idx     = 5'(j);
                    m_level   = m_stable[j];
                    m_pend[j] = 1'b0;
                    break;
                end
            end
        end
        if (tick) begin
            if (!m_primed) begin
                m_stable = dip;
                m_primed = 1;
            end else begin
                for (int i = 0; i < 32; i++) begin
                    if (dip[i] !== m_stable[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEBOUNCE_N) begin
                            m_stable[i] = ~m_stable[i];
                            m_pend[i]   = 1'b1;
                            m_run[i]    = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // scoreboard: per-cycle model compare plus accepted-event queue
    initial forever begin
        @(negedge clk);
        chk("sw_stable", sw_stable, m_stable);
        chk("sw_primed", {31'b0, sw_primed}, {31'b0, m_primed});
        chk("event_valid", {31'b0, event_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("event_index", {27'b0, event_index}, {27'b0, m_idx});
            chk("event_level", {31'b0, event_level}, {31'b0, m_level});
        end
        if (event_valid && ready && !rst) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got idx %0d lvl %0d expected none", event_index, event_level);
            end else begin
                chk("accepted_event", {26'b0, event_index, event_level}, {26'b0, exp_q.pop_front()});
            end
        end
    end

    // driver
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        wait_cycles(3);
        chk("reset_stable", sw_stable, 32'h0);
        chk("reset_valid", {31'b0, event_valid}, 32'h0);
        rst = 1'b0;

        // priming
        wait_cycles(2);
        chk("pre_tick_primed", {31'b0, sw_primed}, 32'h0);
        wait_cycles(4);
        chk("prime_stable", sw_stable, 32'h0000_00F0);
        chk("prime_primed", {31'b0, sw_primed}, 32'h1);

        // single rise on bit 3
        exp_q.push_back({5'd3, 1'b1});
        dip = 32'h0000_00F8;
        wait_cycles(20);
        chk("bit3_stable", sw_stable, 32'h0000_00F8);

        // bit 5 chatter, never stable long enough
        repeat (10) begin
            dip[5] = ~dip[5];
            wait_cycles(TICK_DIV);
        end
        wait_cycles(16);
        chk("chatter_stable", sw_stable, 32'h0000_00F8);

        // three simultaneous flips drained in order under backpressure
        ready = 1'b0;
        exp_q.push_back({5'd0, 1'b1});
        exp_q.push_back({5'd7, 1'b0});
        exp_q.push_back({5'd31, 1'b1});
        dip = dip ^ 32'h8000_0081;
        wait_cycles(24);
        chk("stall_valid", {31'b0, event_valid}, 32'h1);
        chk("stall_index", {27'b0, event_index}, 32'd0);
        ready = 1'b1;
        wait_cycles(6);
        chk("multi_stable", sw_stable, 32'h8000_0079);

        // re-flip of bit 2 while slot is occupied coalesces into one event
        ready = 1'b0;
        exp_q.push_back({5'd0, 1'b0});
        exp_q.push_back({5'd2, 1'b0});
        dip[0] = 1'b0;
        wait_cycles(16);
        dip[2] = 1'b1;
        wait_cycles(16);
        dip[2] = 1'b0;
        wait_cycles(16);
        ready = 1'b1;
        wait_cycles(6);
        chk("coalesce_stable", sw_stable, 32'h8000_0078);

        // reset while an event is presented
        ready = 1'b0;
        dip[1] = 1'b1;
        wait_cycles(16);
        chk("pre_reset_valid", {31'b0, event_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, event_valid}, 32'h0);
        chk("async_reset_primed", {31'b0, sw_primed}, 32'h0);
        wait_cycles(2);
        rst = 1'b0;
        ready = 1'b1;
        wait_cycles(3);
        chk("reprime_before_tick", {31'b0, sw_primed}, 32'h0);
        wait_cycles(12);
        chk("reprime_primed", {31'b0, sw_primed}, 32'h1);
        chk("reprime_stable", sw_stable, 32'h8000_007A);
        chk("reprime_valid", {31'b0, event_valid}, 32'h0);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_switch_reader.md
Name: gpio_switch_reader

Overview:
- Consumes the 32-bit DIP_SW word produced by the GPIO board driver.
- The driver refreshes DIP_SW once per 131072-cycle frame, about every 2.6 ms at 50 MHz.
- This block debounces each switch, holds a stable 32-bit switch image, and serializes each debounced change into a valid/ready event stream for the CPU-side I/O logic.
- It is the input-side counterpart of the display/LED multiplexer.

Parameters:
- TICK_DIV, 131072, clock_50 cycles per sample tick; matches the board scan frame; benches use 4.
- DEBOUNCE_N, 3, consecutive differing ticks required before a switch's stable value flips; legal range 1..15.

Ports:
- clock_50  in  1  50 MHz system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- DIP_SW  in  32  raw switch word from the GPIO board block.
- sw_stable  out  32  debounced switch image.
- sw_primed  out  1  high once sw_stable holds a real sample.
- event_valid  out  1  a change event is presented.
- event_ready  in  1  the consumer accepts the event.
- event_index  out  5  switch number that changed.
- event_level  out  1  new debounced level of that switch.

Behaviour:
- Reset (async assert, sync release):
  - tick counter = 0.
  - sw_stable = 0, sw_primed = 0.
  - All per-bit debounce counters = 0, pending mask = 0.
  - event_valid = 0, event_index = 0, event_level = 0.
  - Any in-flight or pending events are discarded.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle strobe when tick_cnt == TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after reset release.
- Priming:
  - On the first tick after reset, sw_stable <= DIP_SW and sw_primed <= 1.
  - No events, no counter activity and no pending bits are generated on that tick.
- Debounce, per bit i, on each later tick:
  - If DIP_SW[i] == sw_stable[i]: cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i]+1.
  - If cnt[i]+1 == DEBOUNCE_N: sw_stable[i] flips, cnt[i] <= 0, pending[i] <= 1.
  - Between ticks, all counters hold.
  - With DEBOUNCE_N=1, a single differing tick flips the bit.
- Event output stage (one registered slot):
  - The slot is free when event_valid == 0, or when event_valid && event_ready in this cycle.
  - If the slot is free and pending != 0:
    - Load event_index = lowest set pending bit.
    - Load event_level = sw_stable[that bit] as of this cycle.
    - Set event_valid = 1.
    - Clear that pending bit.
  - If the slot is free and pending == 0: event_valid <= 0.
  - event_index and event_level are stable while event_valid && !event_ready.
  - Throughput: one event per cycle with ready held high.
- Latency:
  - Tick at cycle T with a completing count: sw_stable and pending update at T+1.
  - event_valid is asserted at T+2 if the slot was free.
- Simultaneous events:
  - If a pending bit is set by a tick in the same cycle the slot loads that same bit, the set wins. The new change remains pending.
  - Multiple bits flipping on one tick are drained in ascending index order.
- Re-flip before drain: a bit that flips again while still pending stays pending as one event. It reports the level current at load time, so changes are coalesced and never duplicated.
- Reset mid-event: event_valid drops asynchronously, and the event is not re-presented.

Optional Feature:
- Macro: GPIO_SW_SYNC_EN.
- Defined: DIP_SW passes through a 2-flop synchronizer (reset to 0) before tick sampling, adding 2 cycles of sampling latency. Priming still uses the synchronized value.
- Undefined: DIP_SW is sampled directly; this is legal because the GPIO board block registers it in the same clock domain.

Decomposition:
- Shared package gpio_board_pkg:
  - GPIO_WIDTH = 32.
  - GPIO_FRAME_CYCLES = 131072.
  - GPIO_IDX_W = 5.
  - Debounce counter width = 4.
  - Lowest-set-bit priority-encode function.
- Sub-module gpio_debounce_bit: per-bit counter, stable flop and change pulse; instantiated 32 times via generate.
- The top level holds the tick divider, priming flag, pending mask and output slot.

Test Plan (TICK_DIV=4, DEBOUNCE_N=3 unless noted):
- Reset with DIP_SW=32'h0000_00F0 -> first tick: sw_stable=32'h0000_00F0, sw_primed=1, event_valid never asserts.
- Bit 3 rises and holds 3 ticks, ready=1 -> sw_stable[3]=1 one cycle after the third tick; one event {index 3, level 1} two cycles after that tick.
- Bit 5 toggles every tick for 10 ticks -> sw_stable[5] unchanged, no events.
- Bits 0, 7 and 31 flip together, ready=0 for 20 cycles then 1 -> events 0, 7, 31 in order, held stable while stalled, accepted on consecutive cycles.
- Bit 2 flips to 1, then back to 0 before the drain, ready=0 -> exactly one index-2 event with the level current at load.
- Assert reset while event_valid=1 -> event_valid=0 immediately; after release, re-priming occurs with no stale events.
